// File: rtl/sha3_pad_1344.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_pad_1344
//  Purpose  : Packs 32-bit message words into 1344-bit Keccak rate blocks,
//             applies multi-rate padding with a domain byte on the final
//             word, and hands blocks to the permutation core (valid/ready).
//  Revision : 1.0  initial release
// ============================================================================
module sha3_pad_1344 #(
  parameter logic [7:0] DOMAIN     = 8'h1F,
  parameter int         RATE_WORDS = 42
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_data,
  input  logic [3:0]                 in_keep,
  input  logic                       in_last,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [RATE_WORDS*32-1:0]   blk_data,
  output logic                       blk_last,
  output logic [5:0]                 word_cnt
);

  localparam int              c_RATE_BITS  = RATE_WORDS * 32;
  localparam logic [7:0]      c_RATE_BYTES = 8'(RATE_WORDS * 4);
  localparam logic [5:0]      c_LAST_WORD  = 6'(RATE_WORDS - 1);
  // Standalone padding block used when the message ends exactly on a block
  // boundary: domain byte at byte 0, final pad bit at the top byte.
  localparam logic [c_RATE_BITS-1:0] c_PAD_BLOCK =
    {8'h80, {(c_RATE_BITS-16){1'b0}}, DOMAIN};

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_SEND      = 2'd1,
    S_SEND_LAST = 2'd2,
    S_PAD_ONLY  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_in_ready;
  logic [c_RATE_BITS-1:0]   r_buf;
  logic [5:0]               r_cnt;
  logic                     r_pad_pend;

  logic [3:0]               w_keep_eff;
  logic [2:0]               w_nbytes;
  logic [31:0]              w_byte_mask;
  logic [31:0]              w_word;
  logic [7:0]               w_pos;
  logic [10:0]              w_wbase;
  logic [10:0]              w_bbase;
  logic                     w_in_fire;
  logic                     w_blk_fire;
  logic                     w_ends_on_boundary;
  logic                     w_block_full;
  logic [c_RATE_BITS-1:0]   w_fill_buf;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers. A word is only taken in FILL and never alongside clr.
  // ---------------------------------------------------------------------------
  assign w_in_fire  = in_valid & r_in_ready & (r_state == S_FILL) & ~clr;
  assign w_blk_fire = blk_valid & blk_ready;

  // Effective keep: non-last words are always full, illegal last keeps are full.
  always_comb begin
    w_keep_eff = 4'hF;
    if (in_last) begin
      case (in_keep)
        4'b0000, 4'b0001, 4'b0011, 4'b0111: w_keep_eff = in_keep;
        default:                            w_keep_eff = 4'hF;
      endcase
    end
  end

  // Byte count of the effective keep (contiguous from byte 0 only).
  always_comb begin
    w_nbytes = 3'd4;
    case (w_keep_eff)
      4'b0000: w_nbytes = 3'd0;
      4'b0001: w_nbytes = 3'd1;
      4'b0011: w_nbytes = 3'd2;
      4'b0111: w_nbytes = 3'd3;
      default: w_nbytes = 3'd4;
    endcase
  end

  assign w_byte_mask = {{8{w_keep_eff[3]}}, {8{w_keep_eff[2]}},
                        {8{w_keep_eff[1]}}, {8{w_keep_eff[0]}}};
  assign w_word      = in_data & w_byte_mask;

  // Byte position just past the message within the block, and bit offsets.
  assign w_pos   = {r_cnt, 2'b00} + {5'd0, w_nbytes};
  assign w_wbase = {r_cnt, 5'b00000};
  assign w_bbase = {w_pos, 3'b000};

  assign w_ends_on_boundary = in_last & (w_pos == c_RATE_BYTES);
  assign w_block_full       = (r_cnt == c_LAST_WORD);

  // Buffer image after accepting the current word, including padding when it
  // is the last word and the pad still fits inside this block.
  always_comb begin
    w_fill_buf = r_buf;
    w_fill_buf[w_wbase +: 32] = w_word;
    if (in_last && (w_pos < c_RATE_BYTES)) begin
      w_fill_buf[w_bbase +: 8] = w_fill_buf[w_bbase +: 8] ^ DOMAIN;
      w_fill_buf[c_RATE_BITS-1 -: 8] = w_fill_buf[c_RATE_BITS-1 -: 8] | 8'h80;
    end
  end

  // Next-state logic; clr overrides every other event.
  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = S_FILL;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            if (in_last) begin
              w_state_next = w_ends_on_boundary ? S_SEND : S_SEND_LAST;
            end else if (w_block_full) begin
              w_state_next = S_SEND;
            end
          end
        end
        S_SEND: begin
          if (w_blk_fire) begin
            w_state_next = r_pad_pend ? S_PAD_ONLY : S_FILL;
          end
        end
        S_PAD_ONLY: begin
          w_state_next = S_SEND_LAST;
        end
        S_SEND_LAST: begin
          if (w_blk_fire) begin
            w_state_next = S_FILL;
          end
        end
        default: w_state_next = S_FILL;
      endcase
    end
  end

  // State register; in_ready is registered so it only rises once FILL is entered.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= S_FILL;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == S_FILL);
    end
  end

  // Block buffer, word counter and pending-pad flag.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_buf      <= '0;
      r_cnt      <= 6'd0;
      r_pad_pend <= 1'b0;
    end else if (clr) begin
      r_buf      <= '0;
      r_cnt      <= 6'd0;
      r_pad_pend <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            r_buf <= w_fill_buf;
            if (in_last) begin
              r_cnt      <= 6'd0;
              r_pad_pend <= w_ends_on_boundary;
            end else if (w_block_full) begin
              r_cnt <= 6'd0;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        S_SEND: begin
          if (w_blk_fire) begin
            r_buf <= '0;
          end
        end
        S_PAD_ONLY: begin
          r_buf      <= c_PAD_BLOCK;
          r_pad_pend <= 1'b0;
        end
        S_SEND_LAST: begin
          if (w_blk_fire) begin
            r_buf <= '0;
          end
        end
        default: begin
          r_buf <= '0;
          r_cnt <= 6'd0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign blk_valid = (r_state == S_SEND) || (r_state == S_SEND_LAST);
  assign blk_last  = (r_state == S_SEND_LAST);
  assign blk_data  = r_buf;
  assign word_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sha3_pad_1344.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha3_pad_1344
//  Purpose  : Directed self-checking bench for sha3_pad_1344.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha3_pad_1344;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [3:0]    in_keep = '0;
  logic          in_last = 1'b0;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [1343:0] blk_data;
  logic          blk_last;
  logic [5:0]    word_cnt;

  int tests_run = 0;
  int fail_cnt  = 0;

  sha3_pad_1344 #(.DOMAIN(8'h1F), .RATE_WORDS(42)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .word_cnt  (word_cnt)
  );

  always #5 ACLK = ~ACLK;

  // Offer one word starting at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    while (!in_ready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge ACLK);
    in_valid = 1'b0; in_last = 1'b0; in_keep = 4'h0; in_data = '0;
  endtask

  task automatic blk_accept();
    blk_ready = 1'b1;
    @(negedge ACLK);
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    tests_run++;
    if ({in_ready, blk_valid, blk_last, word_cnt} !== 9'd0) begin
      fail_cnt++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b cnt=%0d required all 0",
               in_ready, blk_valid, blk_last, word_cnt);
    end
    tests_run++;
    if (blk_data !== '0) begin
      fail_cnt++;
      $display("FAIL reset_data: got nonzero blk_data required 0");
    end
    ARESETN = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_rdy_early: got %b required 0", in_ready);
    end
    @(negedge ACLK);
    tests_run++;
    if (in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_rdy_rise: got %b required 1", in_ready);
    end
  endtask

  task automatic test_empty();
    logic [1343:0] exp;
    exp = '0;
    exp[7:0]       = 8'h1F;
    exp[1343:1336] = 8'h80;
    push(32'hDEADBEEF, 4'b0000, 1'b1);
    tests_run++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1 || in_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL empty_ctrl: got vld=%b last=%b rdy=%b required 1 1 0",
               blk_valid, blk_last, in_ready);
    end
    tests_run++;
    if (blk_data !== exp) begin
      fail_cnt++;
      $display("FAIL empty_data: got %h required %h", blk_data, exp);
    end
    blk_accept();
    tests_run++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL empty_after: got rdy=%b vld=%b required 1 0", in_ready, blk_valid);
    end
  endtask

  task automatic test_abc(input string tag);
    logic [1343:0] exp;
    exp = '0;
    exp[31:0]      = 32'h1F636261;
    exp[1343:1336] = 8'h80;
    push(32'hA5636261, 4'b0111, 1'b1);
    tests_run++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      fail_cnt++;
      $display("FAIL %s_ctrl: got vld=%b last=%b required 1 1", tag, blk_valid, blk_last);
    end
    tests_run++;
    if (blk_data !== exp) begin
      fail_cnt++;
      $display("FAIL %s_data: got %h required %h", tag, blk_data, exp);
    end
    blk_accept();
    tests_run++;
    if (in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL %s_rdy: got %b required 1", tag, in_ready);
    end
  endtask

  task automatic test_167();
    logic [1343:0] exp;
    exp = '0;
    for (int i = 0; i < 41; i++) begin
      exp[32*i +: 32] = {4{8'(i + 1)}};
      push({4{8'(i + 1)}}, 4'b1111, 1'b0);
    end
    tests_run++;
    if (word_cnt !== 6'd41) begin
      fail_cnt++;
      $display("FAIL b167_cnt: got %0d required 41", word_cnt);
    end
    exp[1335:1312] = 24'hC3B2A1;
    exp[1343:1336] = 8'h9F;
    push(32'h77C3B2A1, 4'b0111, 1'b1);
    tests_run++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      fail_cnt++;
      $display("FAIL b167_ctrl: got vld=%b last=%b required 1 1", blk_valid, blk_last);
    end
    tests_run++;
    if (blk_data !== exp) begin
      fail_cnt++;
      $display("FAIL b167_data: got %h required %h", blk_data, exp);
    end
    blk_accept();
  endtask

  task automatic test_168();
    logic [1343:0] exp;
    logic [1343:0] pad;
    exp = '0;
    pad = '0;
    pad[7:0]       = 8'h1F;
    pad[1343:1336] = 8'h80;
    for (int i = 0; i < 42; i++) begin
      exp[32*i +: 32] = 32'h10203040 + 32'(i);
      push(32'h10203040 + 32'(i), 4'b1111, (i == 41));
    end
    tests_run++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b0 || blk_data !== exp) begin
      fail_cnt++;
      $display("FAIL b168_blk1: got vld=%b last=%b data=%h required 1 0 %h",
               blk_valid, blk_last, blk_data, exp);
    end
    blk_accept();
    tests_run++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b168_gap: got vld=%b rdy=%b required 0 0", blk_valid, in_ready);
    end
    @(negedge ACLK);
    tests_run++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      fail_cnt++;
      $display("FAIL b168_pad_ctrl: got vld=%b last=%b required 1 1", blk_valid, blk_last);
    end
    tests_run++;
    if (blk_data !== pad) begin
      fail_cnt++;
      $display("FAIL b168_pad_data: got %h required %h", blk_data, pad);
    end
    blk_accept();
    tests_run++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b168_after: got rdy=%b vld=%b required 1 0", in_ready, blk_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [1343:0] exp;
    exp = '0;
    exp[31:0]      = 32'h1F636261;
    exp[1343:1336] = 8'h80;
    push(32'h00636261, 4'b0111, 1'b1);
    // Offer a word throughout the stall; it must not be consumed.
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_keep = 4'hF; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      tests_run++;
      if (blk_valid !== 1'b1 || blk_last !== 1'b1 || in_ready !== 1'b0 ||
          word_cnt !== 6'd0 || blk_data !== exp) begin
        fail_cnt++;
        $display("FAIL bp_hold%0d: got vld=%b last=%b rdy=%b cnt=%0d data_ok=%b required 1 1 0 0 1",
                 i, blk_valid, blk_last, in_ready, word_cnt, (blk_data === exp));
      end
    end
    in_valid = 1'b0;
    blk_accept();
    tests_run++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0 || word_cnt !== 6'd0) begin
      fail_cnt++;
      $display("FAIL bp_release: got rdy=%b vld=%b cnt=%0d required 1 0 0",
               in_ready, blk_valid, word_cnt);
    end
  endtask

  task automatic test_abort_clr();
    for (int i = 0; i < 10; i++) push(32'h55AA0000 + 32'(i), 4'hF, 1'b0);
    tests_run++;
    if (word_cnt !== 6'd10) begin
      fail_cnt++;
      $display("FAIL clr_pre_cnt: got %0d required 10", word_cnt);
    end
    clr = 1'b1;
    in_valid = 1'b1; in_data = 32'h12345678; in_keep = 4'hF; in_last = 1'b1;
    @(negedge ACLK);
    clr = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (word_cnt !== 6'd0 || blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL clr_state: got cnt=%0d vld=%b rdy=%b required 0 0 1",
               word_cnt, blk_valid, in_ready);
    end
    test_abc("clr_abc");
  endtask

  task automatic test_abort_rst();
    for (int i = 0; i < 10; i++) push(32'h66BB0000 + 32'(i), 4'hF, 1'b0);
    #2;
    ARESETN = 1'b0;
    #1;
    tests_run++;
    if (word_cnt !== 6'd0 || blk_valid !== 1'b0 || in_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL rst_state: got cnt=%0d vld=%b rdy=%b required 0 0 0",
               word_cnt, blk_valid, in_ready);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    test_abc("rst_abc");
  endtask

  initial begin
    @(negedge ACLK);
    test_reset();
    test_empty();
    test_abc("abc");
    test_167();
    test_168();
    test_backpressure();
    test_abort_clr();
    test_abort_rst();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
